seg_display_scanner: RTL and testbench
======================================

// Module: seg_display_scanner
// PURPOSE
//   Time-multiplexes one shared bcd_to_seven_segment decoder across NUM_DIGITS
//   common-cathode digits. Holds a frame of packed BCD nibbles, steps a one-hot
//   digit enable and drives the nibble for the active digit to the decoder.
//   New frames are accepted by valid/ready and applied only at frame boundaries.
// PARAMETERS
//   NUM_DIGITS   4     digits scanned, >=2
//   REFRESH_DIV  1000  clk cycles per digit slot, >=2 (1 gap cycle + REFRESH_DIV-1 on)
// PORTS
//   clk         in   1              single clock, rising edge
//   rst         in   1              synchronous, active-high reset
//   load_valid  in   1              load_data valid
//   load_ready  out  1              block can accept load_data
//   load_data   in   4*NUM_DIGITS   packed BCD; [3:0] = digit 0 (rightmost)
//   bcd         out  4              nibble to shared decoder's bcd input
//   digit_en    out  NUM_DIGITS     one-hot active-high digit enable, 0 = all off
//   blank       out  1              1 when digit_en == 0
//   frame_done  out  1              1-cycle pulse at end of digit NUM_DIGITS-1 slot
// BEHAVIOUR
//   Reset (rst=1 at edge, any state): state=IDLE, digit_en=0, bcd=0, blank=1,
//     load_ready=1, frame_done=0, pending=0, index=0, slot counter=0.
//     Display and shadow registers cleared to 0. Mid-scan reset aborts immediately.
//   All outputs registered; bcd and digit_en always change on the same edge.
//   States: IDLE -> GAP -> ON -> GAP ... ; never returns to IDLE except by rst.
//   IDLE: outputs as reset. Accept (load_valid&&load_ready) writes display reg,
//     next state GAP with index=0, counter=0.
//   GAP (1 cycle): digit_en=0, bcd=display[index]; anti-ghosting guard. -> ON.
//   ON (REFRESH_DIV-1 cycles): digit_en=1<<index, bcd=display[index].
//     Last ON cycle: index wraps NUM_DIGITS-1 -> 0, else increments; -> GAP.
//   Frame boundary = last ON cycle of index NUM_DIGITS-1: frame_done=1 on the
//     following cycle (first GAP of digit 0), 0 otherwise.
//   Handshake outside IDLE: load_ready = ~pending. Accept stores shadow,
//     sets pending. At boundary: display<=shadow, pending<=0; load_ready=1 next cycle.
//   Accept on the boundary cycle itself (pending=0): load_data goes straight to
//     display at that boundary, pending stays 0. load_valid while !ready ignored;
//     load_data need not be held after acceptance.
//   Invalid nibble (>9) in display: slot still timed, digit_en held 0, bcd=4'hF.
//   Counter width $clog2(REFRESH_DIV); index width $clog2(NUM_DIGITS); no
//     arithmetic on BCD values besides the >9 compare.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: digits above the highest nonzero digit that
//     hold 0 keep digit_en=0 for their slot (bcd still driven); digit 0 always
//     shown, so frame 0x0000 shows a single "0". Timing and frame_done unchanged.
//   Undefined: every valid digit shown, including leading zeros.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4 unless noted)
//   Reset then idle 20 cycles, no load -> digit_en=0, blank=1, bcd=0, load_ready=1.
//   Load 16'h1234 from IDLE -> GAP, then 3 cycles digit_en=0001 bcd=4, ..., digit
//     3 bcd=1; frame_done pulses every 16 cycles.
//   Load 16'h5678 mid-frame -> load_ready drops, old digits finish frame, new
//     value from next digit 0; load_ready high the cycle after boundary.
//   Load 16'h9A00 -> digit 2 slot digit_en=0, bcd=F; other slots normal.
//   Assert rst during ON of digit 2 -> next cycle all reset values, state IDLE.
//   With LEADING_ZERO_BLANK_EN, load 16'h0045 -> digits 2,3 dark, 0,1 lit;
//     16'h0000 -> only digit 0 lit with bcd=0.

Source files
------------

// File: rtl/seg_display_scanner.sv
// Multiplexed 7-segment scanner: one shared BCD decoder, one-hot digit enable.
// Optional LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always lit).
module seg_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [3:0]              bcd,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    blank,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_ON
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     disp_q, disp_d;
  logic [DW-1:0]     shad_q, shad_d;
  logic              pend_q, pend_d;
  logic [3:0]        bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;
  logic              blank_q, blank_d;
  logic              fd_q, fd_d;
  logic              rdy_q, rdy_d;

  logic              accept;
  logic              last_on;
  logic              boundary;
  logic [3:0]        nib;
  logic [NUM_DIGITS-1:0] lz;

  assign accept   = load_valid && rdy_q;
  assign last_on  = (state_q == S_ON) && (cnt_q == CNT_LAST);
  assign boundary = last_on && (idx_q == IDX_LAST);

  assign load_ready = rdy_q;
  assign bcd        = bcd_q;
  assign digit_en   = en_q;
  assign blank      = blank_q;
  assign frame_done = fd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      shad_q  <= '0;
      pend_q  <= 1'b0;
      bcd_q   <= 4'h0;
      en_q    <= '0;
      blank_q <= 1'b1;
      fd_q    <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      shad_q  <= shad_d;
      pend_q  <= pend_d;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
      blank_q <= blank_d;
      fd_q    <= fd_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_GAP;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_GAP: begin
        state_d = S_ON;
        cnt_d   = cnt_q + 1'b1;
      end
      S_ON: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) idx_d = '0;
          else                   idx_d = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // New frames land only at frame boundaries; mid-frame loads wait in shadow.
  always_comb begin
    disp_d = disp_q;
    shad_d = shad_q;
    pend_d = pend_q;
    if (state_q == S_IDLE) begin
      if (accept) disp_d = load_data;
    end else if (boundary) begin
      if (pend_q)      disp_d = shad_q;
      else if (accept) disp_d = load_data;
      pend_d = 1'b0;
    end else if (accept) begin
      shad_d = load_data;
      pend_d = 1'b1;
    end
  end

  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IW'(i)) nib = disp_d[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic above;
    above = 1'b0;
    lz    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      above = above | (disp_d[4*i +: 4] != 4'h0);
      lz[i] = !above && (i != 0);
    end
  end
`else
  assign lz = '0;
`endif

  // Outputs are computed from next-state values so they register with state.
  always_comb begin
    bcd_d   = 4'h0;
    en_d    = '0;
    rdy_d   = 1'b1;
    fd_d    = boundary;
    if (state_d != S_IDLE) begin
      rdy_d = !pend_d;
      if (nib > 4'd9) bcd_d = 4'hF;
      else            bcd_d = nib;
      if ((state_d == S_ON) && (nib <= 4'd9) && !lz[idx_d])
        en_d = NUM_DIGITS'(1) << idx_d;
    end
    blank_d = (en_d == '0);
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner, NUM_DIGITS=4 REFRESH_DIV=4.
// Walks whole frames slot by slot against hand-computed digit values.
module tb_seg_display_scanner;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  bcd;
  logic [3:0]  digit_en;
  logic        blank;
  logic        frame_done;

  int n_total;
  int n_pass;

  seg_display_scanner #(
    .NUM_DIGITS (4),
    .REFRESH_DIV(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .bcd       (bcd),
    .digit_en  (digit_en),
    .blank     (blank),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starts at the slot's gap cycle, ends at the next slot's gap cycle.
  // ldpos: 0 none, 1 load offered on gap, 2 load offered on last ON cycle.
  task automatic run_slot(input string tag,
                          input logic [3:0] b,
                          input logic [3:0] en,
                          input logic fd,
                          input int ldpos,
                          input logic [15:0] ld);
    check({tag, ".gap.en"}, 32'(digit_en), 32'h0);
    check({tag, ".gap.blank"}, 32'(blank), 32'h1);
    check({tag, ".gap.bcd"}, 32'(bcd), 32'(b));
    check({tag, ".gap.fd"}, 32'(frame_done), 32'(fd));
    if (ldpos == 1) begin
      load_valid = 1'b1;
      load_data  = ld;
    end
    step();
    load_valid = 1'b0;
    load_data  = 16'h0;
    for (int k = 0; k < 3; k++) begin
      check({tag, ".on.en"}, 32'(digit_en), 32'(en));
      check({tag, ".on.bcd"}, 32'(bcd), 32'(b));
      check({tag, ".on.blank"}, 32'(blank), 32'(en == 4'h0));
      check({tag, ".on.fd"}, 32'(frame_done), 32'h0);
      if (k == 2 && ldpos == 2) begin
        load_valid = 1'b1;
        load_data  = ld;
      end
      step();
      load_valid = 1'b0;
      load_data  = 16'h0;
    end
  endtask

  logic [3:0] lz2, lz3, lz1;

  initial begin
    n_total    = 0;
    n_pass     = 0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;
`ifdef LEADING_ZERO_BLANK_EN
    lz1 = 4'b0000;
    lz2 = 4'b0000;
    lz3 = 4'b0000;
`else
    lz1 = 4'b0010;
    lz2 = 4'b0100;
    lz3 = 4'b1000;
`endif
    step();
    step();
    rst = 1'b0;
    repeat (20) step();
    check("idle.en", 32'(digit_en), 32'h0);
    check("idle.blank", 32'(blank), 32'h1);
    check("idle.bcd", 32'(bcd), 32'h0);
    check("idle.rdy", 32'(load_ready), 32'h1);
    check("idle.fd", 32'(frame_done), 32'h0);

    // Frame A: 1234 loaded from idle
    load_valid = 1'b1;
    load_data  = 16'h1234;
    step();
    load_valid = 1'b0;
    load_data  = 16'h0;
    check("A.rdy", 32'(load_ready), 32'h1);
    run_slot("A0", 4'h4, 4'b0001, 1'b0, 0, 16'h0);
    run_slot("A1", 4'h3, 4'b0010, 1'b0, 0, 16'h0);
    run_slot("A2", 4'h2, 4'b0100, 1'b0, 0, 16'h0);
    run_slot("A3", 4'h1, 4'b1000, 1'b0, 0, 16'h0);

    // Frame B: 5678 loaded mid-frame, later load ignored
    run_slot("B0", 4'h4, 4'b0001, 1'b1, 0, 16'h0);
    run_slot("B1", 4'h3, 4'b0010, 1'b0, 1, 16'h5678);
    check("B.rdy_low", 32'(load_ready), 32'h0);
    run_slot("B2", 4'h2, 4'b0100, 1'b0, 1, 16'h1111);
    check("B.rdy_low2", 32'(load_ready), 32'h0);
    run_slot("B3", 4'h1, 4'b1000, 1'b0, 0, 16'h0);
    check("C.rdy_high", 32'(load_ready), 32'h1);

    // Frame C: 5678
    run_slot("C0", 4'h8, 4'b0001, 1'b1, 0, 16'h0);
    run_slot("C1", 4'h7, 4'b0010, 1'b0, 0, 16'h0);
    run_slot("C2", 4'h6, 4'b0100, 1'b0, 0, 16'h0);
    run_slot("C3", 4'h5, 4'b1000, 1'b0, 0, 16'h0);

    // Frame D: 5678, 9A00 offered on the boundary cycle
    run_slot("D0", 4'h8, 4'b0001, 1'b1, 0, 16'h0);
    run_slot("D1", 4'h7, 4'b0010, 1'b0, 0, 16'h0);
    run_slot("D2", 4'h6, 4'b0100, 1'b0, 0, 16'h0);
    run_slot("D3", 4'h5, 4'b1000, 1'b0, 2, 16'h9A00);
    check("E.rdy", 32'(load_ready), 32'h1);

    // Frame E: 9A00, digit 2 invalid
    run_slot("E0", 4'h0, 4'b0001, 1'b1, 0, 16'h0);
    run_slot("E1", 4'h0, 4'b0010, 1'b0, 0, 16'h0);
    run_slot("E2", 4'hF, 4'b0000, 1'b0, 0, 16'h0);
    run_slot("E3", 4'h9, 4'b1000, 1'b0, 0, 16'h0);

    // Frame F: 9A00 again, 1234 queued
    run_slot("F0", 4'h0, 4'b0001, 1'b1, 1, 16'h1234);
    run_slot("F1", 4'h0, 4'b0010, 1'b0, 0, 16'h0);
    run_slot("F2", 4'hF, 4'b0000, 1'b0, 0, 16'h0);
    run_slot("F3", 4'h9, 4'b1000, 1'b0, 0, 16'h0);

    // Frame G: 1234, reset during ON of digit 2
    run_slot("G0", 4'h4, 4'b0001, 1'b1, 0, 16'h0);
    run_slot("G1", 4'h3, 4'b0010, 1'b0, 0, 16'h0);
    check("G2.gap.bcd", 32'(bcd), 32'h2);
    step();
    check("G2.on.en", 32'(digit_en), 32'h4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst.en", 32'(digit_en), 32'h0);
    check("rst.bcd", 32'(bcd), 32'h0);
    check("rst.blank", 32'(blank), 32'h1);
    check("rst.rdy", 32'(load_ready), 32'h1);
    check("rst.fd", 32'(frame_done), 32'h0);
    repeat (6) step();
    check("rst.idle.en", 32'(digit_en), 32'h0);
    check("rst.idle.bcd", 32'(bcd), 32'h0);

    // Frame H: 0045, then 0000 on boundary
    load_valid = 1'b1;
    load_data  = 16'h0045;
    step();
    load_valid = 1'b0;
    load_data  = 16'h0;
    run_slot("H0", 4'h5, 4'b0001, 1'b0, 0, 16'h0);
    run_slot("H1", 4'h4, 4'b0010, 1'b0, 0, 16'h0);
    run_slot("H2", 4'h0, lz2, 1'b0, 0, 16'h0);
    run_slot("H3", 4'h0, lz3, 1'b0, 2, 16'h0000);

    // Frame I: 0000
    run_slot("I0", 4'h0, 4'b0001, 1'b1, 0, 16'h0);
    run_slot("I1", 4'h0, lz1, 1'b0, 0, 16'h0);
    run_slot("I2", 4'h0, lz2, 1'b0, 0, 16'h0);
    run_slot("I3", 4'h0, lz3, 1'b0, 0, 16'h0);
    check("I.end.fd", 32'(frame_done), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
